// File: rtl/decode_buffer.sv
// decode_buffer
//    Multi-lane decode stage between fetch and rename/dispatch. Each fetch
//    packet carries up to NR_LANES 32-bit words. Every lane has its own
//    static_decoder. The decoded C::si_t records are queued in a circular
//    buffer of DEPTH entries. Up to NR_LANES of the oldest entries are
//    presented to the consumer every cycle.
//
//    Ports
//       clk_i          clock, rising edge
//       rst_ni         synchronous active-low reset
//       flush_i        drop all buffered entries and leave POISON
//       fetch_valid_i  a fetch packet is present
//       fetch_ready_o  the packet is taken when valid && ready
//       fetch_pc_i     PC of lane 0; lane k sits at fetch_pc_i + 4k
//       fetch_data_i   lane k is at bits [32k+31:32k]
//       fetch_mask_i   lane-valid bits, contiguous from bit 0
//       si_o           buffered records; si_o[0] is the oldest
//       si_valid_o     thermometer: bit k is set iff count > k
//       deq_cnt_i      number of entries the consumer takes this cycle
//       count_o        number of buffered entries
//       poisoned_o     an illegal word was enqueued; intake is stopped
//
//    state  | meaning
//    RUN    | normal intake; packets accepted while a whole packet fits
//    POISON | illegal word enqueued; no intake until flush or reset

package C;
   localparam int XLEN = 32;

   typedef struct packed {
      logic            valid;   // 0 = illegal encoding; consumer raises exception
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic            alt;     // instr[30]: SUB/SRA/SRAI selector
      logic            rd_we;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [31:0]     imm;
   } si_t;
endpackage

// static_decoder
//    Purely combinational RV32I decoder for a single word.
//    Ports: instr_i (word), pc_i (its PC), si_o (decoded record).
//    Register fields are reported only when the format uses them. Unused
//    fields read as zero.
module static_decoder (
   input  logic [31:0]        instr_i,
   input  logic [C::XLEN-1:0] pc_i,
   output C::si_t             si_o
);

   logic [31:0] imm_i_type;
   logic [31:0] imm_s_type;
   logic [31:0] imm_b_type;
   logic [31:0] imm_u_type;
   logic [31:0] imm_j_type;
   logic [6:0]  funct7;
   logic [2:0]  funct3;

   assign funct7     = instr_i[31:25];
   assign funct3     = instr_i[14:12];
   assign imm_i_type = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_s_type = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_b_type = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
   assign imm_u_type = {instr_i[31:12], 12'b0};
   assign imm_j_type = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};

   always_comb begin
      si_o        = '0;
      si_o.pc     = pc_i;
      si_o.opcode = instr_i[6:0];
      si_o.funct3 = funct3;
      si_o.alt    = instr_i[30];

      case (instr_i[6:0])
         7'h37, 7'h17: begin            // LUI, AUIPC
            si_o.valid = 1'b1;
            si_o.rd_we = 1'b1;
            si_o.imm   = imm_u_type;
         end
         7'h6F: begin                   // JAL
            si_o.valid = 1'b1;
            si_o.rd_we = 1'b1;
            si_o.imm   = imm_j_type;
         end
         7'h67: begin                   // JALR
            si_o.valid = (funct3 == 3'd0);
            si_o.rd_we = 1'b1;
            si_o.rs1   = instr_i[19:15];
            si_o.imm   = imm_i_type;
         end
         7'h63: begin                   // branches; funct3 2 and 3 are unused
            si_o.valid = (funct3 != 3'd2) && (funct3 != 3'd3);
            si_o.rs1   = instr_i[19:15];
            si_o.rs2   = instr_i[24:20];
            si_o.imm   = imm_b_type;
         end
         7'h03: begin                   // loads: LB LH LW LBU LHU
            si_o.valid = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
            si_o.rd_we = 1'b1;
            si_o.rs1   = instr_i[19:15];
            si_o.imm   = imm_i_type;
         end
         7'h23: begin                   // stores: SB SH SW
            si_o.valid = (funct3 <= 3'd2);
            si_o.rs1   = instr_i[19:15];
            si_o.rs2   = instr_i[24:20];
            si_o.imm   = imm_s_type;
         end
         7'h13: begin                   // OP-IMM; shifts carry shamt in imm
            si_o.rd_we = 1'b1;
            si_o.rs1   = instr_i[19:15];
            if (funct3 == 3'd1) begin
               si_o.valid = (funct7 == 7'h00);
               si_o.imm   = {27'b0, instr_i[24:20]};
            end else if (funct3 == 3'd5) begin
               si_o.valid = (funct7 == 7'h00) || (funct7 == 7'h20);
               si_o.imm   = {27'b0, instr_i[24:20]};
            end else begin
               si_o.valid = 1'b1;
               si_o.imm   = imm_i_type;
            end
         end
         7'h33: begin                   // OP; funct7 0x20 only for SUB/SRA
            si_o.valid = (funct7 == 7'h00) ||
                         ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
            si_o.rd_we = 1'b1;
            si_o.rs1   = instr_i[19:15];
            si_o.rs2   = instr_i[24:20];
         end
         7'h0F: begin                   // FENCE
            si_o.valid = (funct3 == 3'd0);
         end
         7'h73: begin                   // ECALL/EBREAK, Zicsr
            if (funct3 == 3'd0) begin
               si_o.valid = (instr_i == 32'h0000_0073) || (instr_i == 32'h0010_0073);
            end else begin
               si_o.valid = (funct3 != 3'd4);
               si_o.rd_we = 1'b1;
               si_o.rs1   = instr_i[19:15];
               si_o.imm   = {20'b0, instr_i[31:20]};
            end
         end
         default: si_o.valid = 1'b0;
      endcase

      if (si_o.rd_we) begin
         si_o.rd = instr_i[11:7];
      end
   end

endmodule

module decode_buffer #(
   parameter int NR_LANES = 2,
   parameter int DEPTH    = 8
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            flush_i,
   input  logic                            fetch_valid_i,
   output logic                            fetch_ready_o,
   input  logic [C::XLEN-1:0]              fetch_pc_i,
   input  logic [32*NR_LANES-1:0]          fetch_data_i,
   input  logic [NR_LANES-1:0]             fetch_mask_i,
   output C::si_t [NR_LANES-1:0]           si_o,
   output logic [NR_LANES-1:0]             si_valid_o,
   input  logic [$clog2(NR_LANES+1)-1:0]   deq_cnt_i,
   output logic [$clog2(DEPTH+1)-1:0]      count_o,
   output logic                            poisoned_o
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH+1);
   localparam int LANE_W = $clog2(NR_LANES+1);

   typedef enum logic {RUN, POISON} state_e;

   C::si_t            lane_si [NR_LANES];
   C::si_t            mem_q   [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   state_e            state_q;

   logic [LANE_W-1:0] lane_cnt;
   logic [LANE_W-1:0] enq_cnt;
   logic              enq_ill;
   logic              fetch_accept;
   logic              do_enq;
   logic [CNT_W-1:0]  enq_eff;
   logic [CNT_W-1:0]  deq_ext;
   logic [CNT_W-1:0]  deq_eff;

   for (genvar g = 0; g < NR_LANES; g++) begin : g_lane
      static_decoder u_dec (
         .instr_i (fetch_data_i[32*g +: 32]),
         .pc_i    (fetch_pc_i + C::XLEN'(4*g)),
         .si_o    (lane_si[g])
      );
   end

   // Lanes 0..m-1 are candidates. Intake stops right after the first illegal
   // lane, so that lane still reaches the consumer and can trap.
   always_comb begin
      lane_cnt = '0;
      for (int k = 0; k < NR_LANES; k++) begin
         lane_cnt = lane_cnt + LANE_W'(fetch_mask_i[k]);
      end
      enq_cnt = '0;
      enq_ill = 1'b0;
      for (int k = 0; k < NR_LANES; k++) begin
         if ((LANE_W'(k) < lane_cnt) && !enq_ill) begin
            enq_cnt = enq_cnt + LANE_W'(1);
            if (!lane_si[k].valid) begin
               enq_ill = 1'b1;
            end
         end
      end
   end

   // Space check uses only the registered count. A dequeue in the same
   // cycle does not help intake, which keeps ready off the deq_cnt_i path.
   assign fetch_ready_o = rst_ni && (state_q == RUN) &&
                          (count_q <= CNT_W'(DEPTH - NR_LANES));
   assign fetch_accept  = fetch_valid_i && fetch_ready_o;
   assign do_enq        = fetch_accept && !flush_i;

   always_comb begin
      enq_eff = do_enq ? CNT_W'(enq_cnt) : '0;
      deq_ext = CNT_W'(deq_cnt_i);
      deq_eff = (deq_ext > count_q) ? count_q : deq_ext;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PTR_W'(deq_eff);
         tail_d  = tail_q + PTR_W'(enq_eff);
         count_d = count_q + enq_eff - deq_eff;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         state_q <= RUN;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         case (state_q)
            RUN:    if (do_enq && enq_ill) state_q <= POISON;
            POISON: if (flush_i)           state_q <= RUN;
         endcase
      end
   end

   // Storage needs no reset: only entries below count_q are ever flagged valid.
   always_ff @(posedge clk_i) begin
      if (rst_ni && do_enq) begin
         for (int k = 0; k < NR_LANES; k++) begin
            if (LANE_W'(k) < enq_cnt) begin
               mem_q[tail_q + PTR_W'(k)] <= lane_si[k];
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NR_LANES; k++) begin
         si_o[k]       = mem_q[head_q + PTR_W'(k)];
         si_valid_o[k] = (count_q > CNT_W'(k));
      end
   end

   assign count_o    = count_q;
   assign poisoned_o = (state_q == POISON);

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (rst_ni && !flush_i) begin
         assert ((deq_ext <= count_q) && (deq_cnt_i <= LANE_W'(NR_LANES)))
            else $error("decode_buffer: deq_cnt_i=%0d exceeds presented entries (count=%0d)",
                        deq_cnt_i, count_q);
      end
   end
`endif

endmodule

// File: tb/tb_decode_buffer.sv
module tb_decode_buffer;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      exp_t        e;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic            flush_i;
   logic            fetch_valid_i;
   logic            fetch_ready_o;
   logic [31:0]     fetch_pc_i;
   logic [63:0]     fetch_data_i;
   logic [1:0]      fetch_mask_i;
   C::si_t [1:0]    si_o;
   logic [1:0]      si_valid_o;
   logic [1:0]      deq_cnt_i;
   logic [3:0]      count_o;
   logic            poisoned_o;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   bit   model_poison = 1'b0;
   exp_t e_none;
   vec_t tbl [11];

   always #5 clk = ~clk;

   decode_buffer #(.NR_LANES(2), .DEPTH(8)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .flush_i       (flush_i),
      .fetch_valid_i (fetch_valid_i),
      .fetch_ready_o (fetch_ready_o),
      .fetch_pc_i    (fetch_pc_i),
      .fetch_data_i  (fetch_data_i),
      .fetch_mask_i  (fetch_mask_i),
      .si_o          (si_o),
      .si_valid_o    (si_valid_o),
      .deq_cnt_i     (deq_cnt_i),
      .count_o       (count_o),
      .poisoned_o    (poisoned_o)
   );

   function automatic exp_t mk(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm);
      exp_t e;
      e.valid = v; e.pc = '0; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
      return e;
   endfunction

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
      return {imm, 5'd0, 3'd0, rd, 7'h13};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endtask

   task automatic check_state(input string nm);
      int qs;
      qs = q.size();
      chk({nm, ".count"},    64'(count_o), 64'(qs));
      chk({nm, ".poisoned"}, 64'(poisoned_o), 64'(model_poison));
      chk({nm, ".ready"},    64'(fetch_ready_o), 64'(!model_poison && qs <= 6));
      chk({nm, ".si_valid"}, 64'(si_valid_o), (qs >= 2) ? 64'd3 : (qs == 1) ? 64'd1 : 64'd0);
   endtask

   task automatic cmp_entry(input C::si_t a, input exp_t e);
      chk("deq.valid", 64'(a.valid), 64'(e.valid));
      chk("deq.pc",    64'(a.pc),    64'(e.pc));
      if (e.valid) begin
         chk("deq.rd",  64'(a.rd),  64'(e.rd));
         chk("deq.rs1", 64'(a.rs1), 64'(e.rs1));
         chk("deq.rs2", 64'(a.rs2), 64'(e.rs2));
         chk("deq.imm", 64'(a.imm), 64'(e.imm));
      end
   endtask

   // One clock cycle. Inputs are driven 1 time unit after a rising edge. The
   // scoreboard compares dequeued entries, then pushes the accepted lanes.
   task automatic cycle(input logic fv, input logic [31:0] pc, input logic [63:0] data,
                        input logic [1:0] mask, input exp_t e0, input exp_t e1,
                        input int deq, input logic fl);
      exp_t el [2];
      int   m;
      bit   acc;
      fetch_valid_i = fv;
      fetch_pc_i    = pc;
      fetch_data_i  = data;
      fetch_mask_i  = mask;
      deq_cnt_i     = 2'(deq);
      flush_i       = fl;
      #1;
      acc = fv && fetch_ready_o;
      if (fl) begin
         q.delete();
         model_poison = 1'b0;
      end else begin
         for (int k = 0; k < deq; k++) begin
            if (q.size() == 0) begin
               chk("deq.underflow", 64'(q.size()), 64'd1);
            end else begin
               cmp_entry(si_o[k], q.pop_front());
            end
         end
         if (acc) begin
            el[0] = e0;
            el[1] = e1;
            m = mask[1] ? 2 : 1;
            for (int k = 0; k < m; k++) begin
               el[k].pc = pc + 32'(4*k);
               q.push_back(el[k]);
               if (!el[k].valid) begin
                  model_poison = 1'b1;
                  break;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      fetch_valid_i = 1'b0;
      deq_cnt_i     = '0;
      flush_i       = 1'b0;
   endtask

   task automatic idle_deq(input int deq);
      cycle(1'b0, 32'h0, 64'h0, 2'b01, e_none, e_none, deq, 1'b0);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (q.size() > 0 && guard < 20) begin
         idle_deq((q.size() >= 2) ? 2 : 1);
         guard++;
      end
      if (guard >= 20) chk("drain.timeout", 64'(guard), 64'd0);
      check_state("drain");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] w_addi, w_add;
      exp_t        x_addi, x_add;

      e_none = mk(1'b1, 5'd0, 5'd0, 5'd0, 32'd0);
      tbl[0]  = '{32'h0050_0093, mk(1, 5'd1, 5'd0, 5'd0, 32'd5)};          // addi x1,x0,5
      tbl[1]  = '{32'h0020_81B3, mk(1, 5'd3, 5'd1, 5'd2, 32'd0)};          // add x3,x1,x2
      tbl[2]  = '{32'h1234_52B7, mk(1, 5'd5, 5'd0, 5'd0, 32'h1234_5000)};  // lui x5,0x12345
      tbl[3]  = '{32'h0020_A423, mk(1, 5'd0, 5'd1, 5'd2, 32'd8)};          // sw x2,8(x1)
      tbl[4]  = '{32'hFE20_8EE3, mk(1, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC)};  // beq x1,x2,-4
      tbl[5]  = '{32'h0080_00EF, mk(1, 5'd1, 5'd0, 5'd0, 32'd8)};          // jal x1,+8
      tbl[6]  = '{32'hFFF1_A203, mk(1, 5'd4, 5'd3, 5'd0, 32'hFFFF_FFFF)};  // lw x4,-1(x3)
      tbl[7]  = '{32'h4073_02B3, mk(1, 5'd5, 5'd6, 5'd7, 32'd0)};          // sub x5,x6,x7
      tbl[8]  = '{32'h0000_0000, mk(0, 5'd0, 5'd0, 5'd0, 32'd0)};          // all zeros
      tbl[9]  = '{32'hFFFF_FFFF, mk(0, 5'd0, 5'd0, 5'd0, 32'd0)};          // all ones
      tbl[10] = '{32'h0420_81B3, mk(0, 5'd0, 5'd0, 5'd0, 32'd0)};          // add, bad funct7

      rst_ni = 1'b0; flush_i = 1'b0; fetch_valid_i = 1'b1;
      fetch_pc_i = '0; fetch_data_i = '0; fetch_mask_i = 2'b11; deq_cnt_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.ready_low", 64'(fetch_ready_o), 64'd0);
      fetch_valid_i = 1'b0;
      rst_ni = 1'b1;
      #1;
      check_state("after_reset");

      // Basic packet: addi x1,x0,5 in lane 0, add x3,x1,x2 in lane 1
      w_addi = 32'h0050_0093; x_addi = tbl[0].e;
      w_add  = 32'h0020_81B3; x_add  = tbl[1].e;
      cycle(1, 32'h8000_0000, {w_add, w_addi}, 2'b11, x_addi, x_add, 0, 0);
      check_state("basic");
      chk("basic.pc0",  64'(si_o[0].pc),  64'h8000_0000);
      chk("basic.imm0", 64'(si_o[0].imm), 64'd5);
      chk("basic.rd0",  64'(si_o[0].rd),  64'd1);
      chk("basic.pc1",  64'(si_o[1].pc),  64'h8000_0004);
      chk("basic.rs1",  64'(si_o[1].rs1), 64'd1);
      chk("basic.rs2",  64'(si_o[1].rs2), 64'd2);
      drain();

      // Decoder table, one word per single-lane packet; lane 1 is masked off
      for (int i = 0; i < 11; i++) begin
         cycle(1, 32'h1000 + 32'(8*i), {32'h0, tbl[i].instr}, 2'b01, tbl[i].e, e_none, 0, 0);
         check_state("vec.enq");
         if (tbl[i].e.valid) begin
            idle_deq(1);
         end else begin
            chk("vec.ill_valid", 64'(si_o[0].valid), 64'd0);
            chk("vec.ill_pc",    64'(si_o[0].pc),    64'(32'h1000 + 32'(8*i)));
            cycle(0, 32'h0, 64'h0, 2'b01, e_none, e_none, 0, 1);
         end
         check_state("vec.after");
      end

      // Illegal lane 0 truncates the packet; intake blocked until flush
      cycle(1, 32'h2000, {w_addi, 32'h0}, 2'b11, tbl[8].e, x_addi, 0, 0);
      check_state("poison");
      chk("poison.valid0", 64'(si_o[0].valid), 64'd0);
      cycle(1, 32'h2100, {w_add, w_addi}, 2'b11, x_addi, x_add, 0, 0);
      check_state("poison.blocked");
      cycle(0, 32'h0, 64'h0, 2'b01, e_none, e_none, 0, 1);
      check_state("poison.flushed");

      // Illegal lane 1: both lanes enqueue, drained while poisoned
      cycle(1, 32'h2200, {32'h0, w_addi}, 2'b11, x_addi, tbl[8].e, 0, 0);
      check_state("poison1");
      idle_deq(2);
      check_state("poison1.drained");
      cycle(0, 32'h0, 64'h0, 2'b01, e_none, e_none, 0, 1);
      check_state("poison1.flushed");

      // Fill to DEPTH, then a single dequeue reopens intake
      for (int i = 0; i < 4; i++) begin
         cycle(1, 32'h3000 + 32'(8*i), {addi(5'(2*i+1), 12'(2*i+1)), addi(5'(2*i), 12'(2*i))},
               2'b11, mk(1, 5'(2*i), 0, 0, 32'(2*i)), mk(1, 5'(2*i+1), 0, 0, 32'(2*i+1)), 0, 0);
      end
      check_state("full");
      cycle(1, 32'h3100, {w_add, w_addi}, 2'b11, x_addi, x_add, 2, 0);
      check_state("full.deq2");
      drain();

      // Partial mask, then simultaneous enqueue 2 / dequeue 1 from count 3
      cycle(1, 32'h4000, {w_add, w_addi}, 2'b11, x_addi, x_add, 0, 0);
      cycle(1, 32'h4008, {w_add, w_addi}, 2'b01, x_addi, x_add, 0, 0);
      check_state("partial");
      cycle(1, 32'h4010, {w_add, w_addi}, 2'b11, x_addi, x_add, 1, 0);
      check_state("enq2deq1");
      drain();

      // Streaming across pointer wrap
      for (int i = 0; i < 20; i++) begin
         cycle(1, 32'h5000 + 32'(8*i),
               {addi(5'((2*i+1) % 32), 12'(2*i+1)), addi(5'((2*i) % 32), 12'(2*i))}, 2'b11,
               mk(1, 5'((2*i) % 32), 0, 0, 32'(2*i)), mk(1, 5'((2*i+1) % 32), 0, 0, 32'(2*i+1)),
               (i == 0) ? 0 : 2, 0);
      end
      check_state("stream");
      drain();

      // Flush together with a packet and a dequeue
      cycle(1, 32'h6000, {w_add, w_addi}, 2'b11, x_addi, x_add, 0, 0);
      cycle(1, 32'h6008, {w_add, w_addi}, 2'b11, x_addi, x_add, 1, 1);
      check_state("flush.busy");

      // Flush together with an illegal packet: stays RUN, nothing enqueued
      cycle(1, 32'h6100, 64'h0, 2'b11, tbl[8].e, tbl[8].e, 0, 1);
      check_state("flush.illegal");

      // Reset mid-operation
      cycle(1, 32'h7000, {w_add, w_addi}, 2'b11, x_addi, x_add, 0, 0);
      rst_ni = 1'b0;
      fetch_valid_i = 1'b1; fetch_mask_i = 2'b11;
      #1;
      chk("midrst.ready_low", 64'(fetch_ready_o), 64'd0);
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      fetch_valid_i = 1'b0;
      q.delete();
      model_poison = 1'b0;
      #1;
      check_state("midrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
